// File: rtl/uart_pkg.sv
// Shared widths, divisor type and divisor helper for the
// fractional UART baud generator.
package uart_pkg;

  localparam int DEF_INT_W  = 16;
  localparam int DEF_FRAC_W = 4;
  localparam int DEF_DIV_W  = DEF_INT_W + DEF_FRAC_W;
  localparam int DEF_OSR    = 16;

  typedef logic [DEF_DIV_W-1:0] div_t;

  // Rounded fixed-point divisor: clk * 2^F / (baud * osr)
  function automatic div_t baud_div(
    input longint unsigned clock_rate,
    input longint unsigned baud,
    input longint unsigned osr,
    input int unsigned     frac_w
  );
    longint unsigned den;
    longint unsigned q;
    den = baud * osr;
    q   = ((clock_rate << frac_w) + den / 2) / den;
    return div_t'(q);
  endfunction

endpackage

// File: rtl/uart_baud_gen_frac_if.sv
// Control/status bundle between the baud generator and
// the UART RX/TX engines.
interface uart_baud_gen_frac_if
  import uart_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int OSR   = DEF_OSR
);
  localparam int P = $clog2(OSR);

  logic             en;
  logic [DIV_W-1:0] div_in;
  logic             div_wr;
  logic             rx_resync;
  logic [DIV_W-1:0] div_cur;
  logic             div_pending;
  logic             div_err;
  logic             rx_tick;
  logic [P-1:0]     rx_phase;
  logic             rx_sample;
  logic             tx_tick;

  modport master (
    output en, div_in, div_wr, rx_resync,
    input  div_cur, div_pending, div_err,
    input  rx_tick, rx_phase, rx_sample, tx_tick
  );

  modport slave (
    input  en, div_in, div_wr, rx_resync,
    output div_cur, div_pending, div_err,
    output rx_tick, rx_phase, rx_sample, tx_tick
  );

endinterface

// File: rtl/uart_frac_accum.sv
// Fractional-N phase accumulator: adds 2^F per enabled
// cycle and fires whenever the sum reaches the divisor.
module uart_frac_accum #(
  parameter int DIV_W  = 20,
  parameter int FRAC_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             fire_o,
  output logic             tick_o
);

  localparam logic [DIV_W:0] STEP =
    {{DIV_W{1'b0}}, 1'b1} << FRAC_W;

  logic [DIV_W-1:0] acc_q, acc_d;
  logic [DIV_W:0]   sum;
  logic             tick_d;

  always_comb begin
    sum    = {1'b0, acc_q} + STEP;
    acc_d  = acc_q;
    tick_d = 1'b0;
    if (en_i) begin
      if (sum >= {1'b0, div_i}) begin
        acc_d  = DIV_W'(sum - {1'b0, div_i});
        tick_d = 1'b1;
      end else begin
        acc_d  = sum[DIV_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      tick_o <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      tick_o <= tick_d;
    end
  end

  assign fire_o = tick_d;

endmodule

// File: rtl/uart_baud_gen_frac.sv
// Fractional UART baud generator: RX oversample tick,
// mid-bit sample strobe, TX bit tick, deferred divisor.
module uart_baud_gen_frac
  import uart_pkg::*;
#(
  parameter int DIV_INT_W  = DEF_INT_W,
  parameter int DIV_FRAC_W = DEF_FRAC_W,
  parameter int OSR        = DEF_OSR,
  parameter int RESET_DIV  =
    int'(baud_div(42_000_000, 115_200, 16, 4))
) (
  input logic                 clk,
  input logic                 rst_n,
  uart_baud_gen_frac_if.slave bus
);

  localparam int W = DIV_INT_W + DIV_FRAC_W;
  localparam int P = $clog2(OSR);

  localparam logic [P-1:0] PH_LAST = P'(OSR - 1);
  localparam logic [P-1:0] PH_MID  = P'(OSR / 2 - 1);
  localparam logic [W-1:0] DIV_MIN = W'(1) << DIV_FRAC_W;
  localparam logic [W-1:0] DIV_RST = W'(RESET_DIV);

  logic         fire;
  logic         rx_tick_q;
  logic         wr_ok, tx_wrap, apply;

  logic [W-1:0] div_cur_q, div_cur_d;
  logic [W-1:0] div_next_q, div_next_d;
  logic         pend_q, pend_d;
  logic         err_q, err_d;
  logic [P-1:0] tx_ph_q, tx_ph_d;
  logic [P-1:0] rx_ph_q, rx_ph_d;
  logic         rx_smp_q, rx_smp_d;
  logic         tx_tick_q, tx_tick_d;

  uart_frac_accum #(
    .DIV_W  (W),
    .FRAC_W (DIV_FRAC_W)
  ) u_accum (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (bus.en),
    .div_i  (div_cur_q),
    .fire_o (fire),
    .tick_o (rx_tick_q)
  );

  always_comb begin
    wr_ok   = bus.div_wr && (bus.div_in >= DIV_MIN);
    tx_wrap = fire && (tx_ph_q == PH_LAST);
    // Divisor swaps only on a bit boundary, or at once when idle
    apply   = pend_q && (tx_wrap || !bus.en);

    div_cur_d  = apply ? div_next_q : div_cur_q;
    div_next_d = wr_ok ? bus.div_in : div_next_q;
    pend_d     = wr_ok || (pend_q && !apply);
    err_d      = bus.div_wr && !wr_ok;

    tx_ph_d = tx_ph_q;
    if (fire)
      tx_ph_d = tx_wrap ? '0 : tx_ph_q + P'(1);

    rx_ph_d = rx_ph_q;
    if (bus.rx_resync)
      rx_ph_d = '0;
    else if (fire)
      rx_ph_d = (rx_ph_q == PH_LAST) ? '0 : rx_ph_q + P'(1);

    rx_smp_d  = fire && !bus.rx_resync && (rx_ph_q == PH_MID);
    tx_tick_d = tx_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cur_q  <= DIV_RST;
      div_next_q <= '0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
      tx_ph_q    <= '0;
      rx_ph_q    <= '0;
      rx_smp_q   <= 1'b0;
      tx_tick_q  <= 1'b0;
    end else begin
      div_cur_q  <= div_cur_d;
      div_next_q <= div_next_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      tx_ph_q    <= tx_ph_d;
      rx_ph_q    <= rx_ph_d;
      rx_smp_q   <= rx_smp_d;
      tx_tick_q  <= tx_tick_d;
    end
  end

  assign bus.div_cur     = div_cur_q;
  assign bus.div_pending = pend_q;
  assign bus.div_err     = err_q;
  assign bus.rx_tick     = rx_tick_q;
  assign bus.rx_phase    = rx_ph_q;
  assign bus.rx_sample   = rx_smp_q;
  assign bus.tx_tick     = tx_tick_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Directed bench for uart_baud_gen_frac with expected
// tick times worked out by hand from the divisor math.
module tb_uart_baud_gen_frac;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;
  int tx_last  = 0;
  int tx_prev  = 0;
  int bad_co   = 0;
  int c0       = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_baud_gen_frac_if bus_if ();

  uart_baud_gen_frac dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (bus_if.tx_tick) begin
      tx_prev = tx_last;
      tx_last = cyc;
    end
    if ((bus_if.tx_tick || bus_if.rx_sample) && !bus_if.rx_tick)
      bad_co++;
  endtask

  task automatic wait_tx();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!bus_if.tx_tick && n < 3000);
    if (!bus_if.tx_tick) check("tx_wait", bus_if.tx_tick, 1);
  endtask

  task automatic wait_rx(input int ph);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(bus_if.rx_tick &&
                 (ph < 0 || int'(bus_if.rx_phase) == ph))
               && n < 3000);
    if (!bus_if.rx_tick) check("rx_wait", bus_if.rx_tick, 1);
  endtask

  initial begin
    int rx_first, smp_first, rx_last;
    int bad_iv, rx_n, smp_n, early, dis_bad, c1;

    bus_if.en        = 1'b0;
    bus_if.div_in    = '0;
    bus_if.div_wr    = 1'b0;
    bus_if.rx_resync = 1'b0;
    repeat (3) tick();

    check("rst_div_cur", bus_if.div_cur, 365);
    check("rst_pending", bus_if.div_pending, 0);
    check("rst_err", bus_if.div_err, 0);
    check("rst_rx_tick", bus_if.rx_tick, 0);
    check("rst_rx_phase", bus_if.rx_phase, 0);
    check("rst_sample", bus_if.rx_sample, 0);
    check("rst_tx_tick", bus_if.tx_tick, 0);

    // Fractional accuracy at 365/16
    rst_n     = 1'b1;
    bus_if.en = 1'b1;
    c0        = cyc;
    rx_first = -1; smp_first = -1; rx_last = -1;
    bad_iv = 0; rx_n = 0; smp_n = 0;
    for (int i = 0; i < 730; i++) begin
      tick();
      if (bus_if.rx_tick) begin
        rx_n++;
        if (rx_last >= 0 && !((cyc - rx_last) inside {22, 23}))
          bad_iv++;
        if (rx_first < 0) rx_first = cyc - c0;
        rx_last = cyc;
      end
      if (bus_if.rx_sample) begin
        smp_n++;
        if (smp_first < 0) smp_first = cyc - c0;
      end
    end
    check("first_rx", rx_first, 23);
    check("rx_intervals", bad_iv, 0);
    check("rx_count", rx_n, 32);
    check("first_sample", smp_first, 183);
    check("sample_count", smp_n, 2);
    check("tx_time", tx_last - c0, 730);
    check("tx_gap_365", tx_last - tx_prev, 365);

    // Minimum divisor, applied at the next bit boundary
    bus_if.div_in = 20'd16;
    bus_if.div_wr = 1'b1;
    tick();
    bus_if.div_wr = 1'b0;
    check("min_pending", bus_if.div_pending, 1);
    check("min_cur_old", bus_if.div_cur, 365);
    wait_tx();
    check("min_apply_t", cyc - c0, 1095);
    check("min_cur_new", bus_if.div_cur, 16);
    check("min_pend_clr", bus_if.div_pending, 0);
    rx_n = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (bus_if.rx_tick) rx_n++;
    end
    check("min_rx_every", rx_n, 32);
    check("min_tx_last", tx_last - c0, 1127);
    check("min_tx_gap", tx_last - tx_prev, 16);

    // Deferred update mid-bit, then a rejected write
    repeat (5) tick();
    bus_if.div_in = 20'd730;
    bus_if.div_wr = 1'b1;
    tick();
    bus_if.div_wr = 1'b0;
    check("def_pending", bus_if.div_pending, 1);
    check("def_cur_old", bus_if.div_cur, 16);
    wait_tx();
    check("def_old_gap", tx_last - tx_prev, 16);
    check("def_cur_new", bus_if.div_cur, 730);
    check("def_pend_clr", bus_if.div_pending, 0);
    wait_tx();
    check("def_new_gap", tx_last - tx_prev, 730);
    check("def_tx_t", tx_last - c0, 1873);
    bus_if.div_in = 20'd5;
    bus_if.div_wr = 1'b1;
    tick();
    bus_if.div_wr = 1'b0;
    check("err_pulse", bus_if.div_err, 1);
    check("err_cur", bus_if.div_cur, 730);
    check("err_pending", bus_if.div_pending, 0);
    tick();
    check("err_clear", bus_if.div_err, 0);

    // Resync at rx_phase 11
    wait_rx(11);
    check("rs_at_11", cyc - c0, 2375);
    bus_if.rx_resync = 1'b1;
    tick();
    bus_if.rx_resync = 1'b0;
    check("rs_phase0", bus_if.rx_phase, 0);
    rx_n = 0; early = 0;
    for (int i = 0; i < 2000 && rx_n < 8; i++) begin
      tick();
      if (bus_if.rx_tick) rx_n++;
      if (rx_n < 8 && bus_if.rx_sample) early++;
    end
    check("rs_sample", bus_if.rx_sample, 1);
    check("rs_phase8", bus_if.rx_phase, 8);
    check("rs_time", cyc - c0, 2740);
    check("rs_early", early, 0);
    check("rs_tx_t", tx_last - c0, 2603);
    check("rs_tx_gap", tx_last - tx_prev, 730);

    // Disable for 50 cycles; a write while idle applies at once
    bus_if.en = 1'b0;
    dis_bad = 0;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (bus_if.rx_tick || bus_if.tx_tick || bus_if.rx_sample)
        dis_bad++;
      if (i == 10) begin
        bus_if.div_in = 20'd800;
        bus_if.div_wr = 1'b1;
      end
      if (i == 11) begin
        bus_if.div_wr = 1'b0;
        check("dis_pending", bus_if.div_pending, 1);
      end
      if (i == 12) begin
        check("dis_cur", bus_if.div_cur, 800);
        check("dis_pend_clr", bus_if.div_pending, 0);
      end
    end
    check("dis_no_ticks", dis_bad, 0);
    check("dis_hold_ph", bus_if.rx_phase, 8);
    bus_if.en = 1'b1;
    wait_rx(-1);
    check("en_resume_t", cyc - c0, 2840);
    check("en_resume_ph", bus_if.rx_phase, 9);

    // Reset mid-bit discards the pending divisor
    bus_if.div_in = 20'd500;
    bus_if.div_wr = 1'b1;
    tick();
    bus_if.div_wr = 1'b0;
    check("pre_rst_pend", bus_if.div_pending, 1);
    tick();
    rst_n = 1'b0;
    #1;
    check("arst_pending", bus_if.div_pending, 0);
    check("arst_cur", bus_if.div_cur, 365);
    check("arst_phase", bus_if.rx_phase, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    c1    = cyc;
    wait_rx(-1);
    check("rst2_first_rx", cyc - c1, 23);
    wait_tx();
    check("rst2_tx_t", cyc - c1, 365);
    check("rst2_cur", bus_if.div_cur, 365);

    check("tick_coincide", bad_co, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_baud_gen_frac.md
# uart_baud_gen_frac

Fractional-N UART baud generator with a runtime-programmable divisor. It produces an oversampling tick for the receiver, a mid-bit sample strobe, and a bit-rate tick for the transmitter. Divisor updates are applied only on bit boundaries. A receiver-driven resync re-aligns the sample phase to a start-bit edge without disturbing the transmit bit clock. It sits between the system clock domain and the UART RX/TX engines.

## Interface
Parameters:
- `DIV_INT_W`, 16: integer bits of the divisor.
- `DIV_FRAC_W`, 4: fractional bits of the divisor. `F = DIV_FRAC_W`.
- `OSR`, 16: oversampling ratio. Even, ≥4.
- `RESET_DIV`, 365: divisor after reset. Unsigned fixed-point `DIV_INT_W.DIV_FRAC_W`. 365/16 = 22.8125 cycles, which is 42 MHz / (115200 × 16).

Ports (`W = DIV_INT_W + DIV_FRAC_W`, `P = $clog2(OSR)`):
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `en`, in, 1: run enable. When 0, all counters hold.
- `div_in`, in, W: new divisor value.
- `div_wr`, in, 1: one-cycle write strobe for `div_in`.
- `rx_resync`, in, 1: restart the RX sample phase (start-bit edge seen).
- `div_cur`, out, W: divisor currently in use.
- `div_pending`, out, 1: a written divisor is waiting for a bit boundary.
- `div_err`, out, 1: one-cycle pulse; the write was rejected.
- `rx_tick`, out, 1: oversample tick, one-cycle pulse.
- `rx_phase`, out, P: count of RX ticks since resync, modulo OSR.
- `rx_sample`, out, 1: mid-bit sample strobe, one-cycle pulse.
- `tx_tick`, out, 1: bit-rate tick, one-cycle pulse.

## Operation
- **Accumulator.**
  - `acc` is W bits. Each enabled cycle, `s = acc + 2^F`, computed at W+1 bits.
  - If `s >= div_cur`: `acc <= s - div_cur` and `rx_tick` is set for the next cycle.
  - Otherwise: `acc <= s`.
  - The mean RX period is `div_cur / 2^F` cycles. Individual intervals are the floor or ceiling of that value.
- **TX phase.** `tx_phase` is P bits. It increments on each `rx_tick` and wraps from OSR-1 to 0. `tx_tick` pulses on the RX tick at which it wraps. The TX period is exactly `OSR × div_cur / 2^F` cycles.
- **RX phase.**
  - `rx_phase` increments on each `rx_tick` and wraps at OSR.
  - `rx_sample` pulses on the RX tick at which `rx_phase` goes from OSR/2-1 to OSR/2.
  - `rx_resync` forces `rx_phase` to 0 on the next edge. This overrides a coincident increment.
  - `rx_resync` leaves `acc` and `tx_phase` untouched.
- **Divisor write.**
  - On `div_wr`, if `div_in < 2^F` (integer part 0), the write is rejected. `div_err` pulses and nothing else changes.
  - Otherwise the value is latched into `div_next` and `div_pending` is set.
  - A later write while pending overwrites `div_next`; last write wins.
  - The pending value is applied to `div_cur` on the edge where `tx_tick` is generated, or on the next edge if `en = 0`. `div_pending` clears on the same edge.
  - `acc` is not cleared by a divisor change.
- **Disable.** When `en = 0`, `acc`, `rx_phase` and `tx_phase` hold, and all tick outputs are 0 from the next edge.
- **Reset values.**
  - `acc = 0`, `rx_phase = 0`, `tx_phase = 0`.
  - `div_cur = RESET_DIV`, `div_pending = 0`.
  - `rx_tick = 0`, `rx_sample = 0`, `tx_tick = 0`, `div_err = 0`.

## Timing
- All outputs are registered, with no combinational path from input to output.
- The first `rx_tick` after reset, with `en = 1` continuously and `RESET_DIV = 365`, is visible in the cycle after the 23rd enabled edge.
- With `div_cur = 2^F`, `rx_tick` is high every enabled cycle.
- `tx_tick` and the `rx_tick` that generates it are high in the same cycle. The same applies to `rx_sample`.
- `div_err` appears 1 cycle after `div_wr`. `div_pending` rises 1 cycle after `div_wr`.
- Reset asserted mid-operation clears all state immediately, including any pending divisor and ticks in flight.

## Structure
- Package `uart_pkg` holds:
  - width localparams derived from `DIV_INT_W` and `DIV_FRAC_W`;
  - the function `baud_div(clock_rate, baud, osr, frac_w)`, which returns the rounded fixed-point divisor for `RESET_DIV`;
  - a typedef for the divisor.
- Sub-module `uart_frac_accum` contains `acc`, the compare/subtract logic and `rx_tick`. The top level contains the phase counters, the divisor register and pending logic, and the output flops.

## Test plan
- **Reset defaults.** Hold `rst_n = 0`, then release with `en = 1`. Expect all outputs 0, `div_cur = 365`, and the first `rx_tick` after 23 edges.
- **Fractional accuracy.** `div = 365`, run 16 RX ticks. Expect intervals of only 22 or 23 cycles, and exactly 365 cycles between consecutive `tx_tick`.
- **Minimum divisor.** Write `div_in = 16`. Expect the write to apply at the next `tx_tick`, then `rx_tick` high every cycle and `tx_tick` every 16 cycles.
- **Deferred update.** Write 730 mid-bit. Expect `div_pending = 1` until the next `tx_tick`, the old bit period unaffected, and the following bit period 730 cycles. Then write 5: expect a `div_err` pulse and `div_cur` unchanged.
- **Resync.** Assert `rx_resync` coincident with an `rx_tick` at `rx_phase = 11`. Expect `rx_phase = 0` and `rx_sample` on the 8th subsequent `rx_tick`, with `tx_tick` spacing unchanged.
- **Disable and reset.** Drop `en` for 50 cycles, then re-enable. Expect no ticks while disabled and the phases resuming where they were. Pulse `rst_n` low mid-bit. Expect immediate return to reset values and the pending divisor discarded.
